// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch/realign stage.
package fetch_pkg;

    localparam int HW_DEPTH = 4;

    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_hwq.sv
// Four-entry halfword FIFO: up to two pushes and two pops per cycle, with flush.
module fetch_hwq
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      flush,
    input  logic [1:0] push_cnt,
    input  halfword_t push_hw0,
    input  halfword_t push_hw1,
    input  logic [1:0] pop_cnt,
    output logic [2:0] count,
    output halfword_t head0,
    output halfword_t head1
);

    halfword_t  slots [HW_DEPTH];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < HW_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_cnt != 2'd0) begin
                slots[wr_ptr] <= push_hw0;
            end
            if (push_cnt == 2'd2) begin
                slots[wr_ptr + 2'd1] <= push_hw1;
            end
            wr_ptr <= wr_ptr + push_cnt;
            rd_ptr <= rd_ptr + pop_cnt;
            count  <= count + {1'b0, push_cnt} - {1'b0, pop_cnt};
        end
    end

    assign head0 = slots[rd_ptr];
    assign head1 = slots[rd_ptr + 2'd1];

endmodule

// File: rtl/fetch_align.sv
// Fetch stage: issues word reads, realigns halfwords into 16/32-bit instructions
// with their PC, and handles redirects including those that hit an in-flight read.
module fetch_align
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_compressed
);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_addr;
    logic [31:0]  pend_addr;
    logic [31:0]  pc;
    logic         drop;
    logic [2:0]   count;
    logic [2:0]   count_next;
    halfword_t    head0;
    halfword_t    head1;
    logic         head_c;
    logic         take;
    logic         complete;
    logic         busy;
    logic         room;
    logic [1:0]   push_cnt;
    logic [1:0]   pop_cnt;
    logic [31:0]  redirect_word;
    logic         unused_redirect_bit;

    assign unused_redirect_bit = redirect_pc[0];
    assign redirect_word       = {redirect_pc[31:2], 2'b00};

    assign head_c         = is_compressed(head0);
    assign out_compressed = head_c;
    assign out_valid      = head_c ? (count >= 3'd1) : (count >= 3'd2);
    assign out_instr      = head_c ? {16'h0000, head0} : {head1, head0};
    assign out_pc         = pc;
    assign take           = out_valid && out_ready;
    assign pop_cnt        = take ? (head_c ? 2'd1 : 2'd2) : 2'd0;

    assign mem_valid = (state != IDLE);
    assign mem_instr = mem_valid;
    assign mem_addr  = fetch_addr;
    assign complete  = mem_valid && mem_ready;
    assign busy      = mem_valid && !mem_ready;

    // Data from a discarded read or one completing under a redirect never enters the queue.
    assign push_cnt   = (complete && state == REQ && !redirect_valid) ? (drop ? 2'd1 : 2'd2) : 2'd0;
    assign count_next = count + {1'b0, push_cnt} - {1'b0, pop_cnt};
    assign room       = redirect_valid || (count_next <= 3'd2);

    fetch_hwq u_hwq (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (redirect_valid),
        .push_cnt (push_cnt),
        .push_hw0 (drop ? mem_rdata[31:16] : mem_rdata[15:0]),
        .push_hw1 (mem_rdata[31:16]),
        .pop_cnt  (pop_cnt),
        .count    (count),
        .head0    (head0),
        .head1    (head1)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (room) state_next = REQ;
            REQ: begin
                if (mem_ready) begin
                    state_next = room ? REQ : IDLE;
                end else if (redirect_valid) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: if (mem_ready) state_next = room ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            pend_addr  <= {RESET_PC[31:2], 2'b00};
            drop       <= RESET_PC[1];
            pc         <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                drop <= redirect_pc[1];
                pc   <= {redirect_pc[31:1], 1'b0};
                // An in-flight read keeps its address; the new target waits in pend_addr.
                if (busy) begin
                    pend_addr <= redirect_word;
                end else begin
                    fetch_addr <= redirect_word;
                end
            end else begin
                if (take) begin
                    pc <= pc + (head_c ? 32'd2 : 32'd4);
                end
                if (complete) begin
                    if (state == REQ) begin
                        fetch_addr <= fetch_addr + 32'd4;
                        drop       <= 1'b0;
                    end else begin
                        fetch_addr <= pend_addr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Randomised and directed bench for fetch_align against an instruction-stream model.
module tb_fetch_align;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_compressed (out_compressed)
    );

    always #5 clk = ~clk;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] tab [128];
    logic [31:0] model_pc;
    logic [31:0] exp_pc_q [$];
    logic [31:0] exp_instr_q [$];
    bit          held;
    logic [31:0] held_addr;
    bit          stall;
    logic [31:0] stall_pc;
    logic [31:0] stall_instr;
    int          cyc;
    int          hs_n;
    int          hs_cyc [2];

    // Memory image repeats every 512 bytes of address space.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return tab[a[8:2]];
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        assert (act === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        mem_ready      = 1'b0;
        mem_rdata      = 32'h0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        resetn   = 1'b1;
        model_pc = 32'h0;
        held     = 1'b0;
        stall    = 1'b0;
        hs_n     = 0;
        exp_pc_q.delete();
        exp_instr_q.delete();
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
        exp_pc_q.push_back(p);
        exp_instr_q.push_back(i);
    endtask

    task automatic push_program_exp();
        push_exp(32'h00, 32'h0000_0013);
        push_exp(32'h04, 32'h0000_0093);
        push_exp(32'h08, 32'h0000_0001);
        push_exp(32'h0A, 32'h0000_4501);
        push_exp(32'h0C, 32'h0000_4505);
        push_exp(32'h0E, 32'h0000_0013);
        push_exp(32'h12, 32'h0000_1111);
    endtask

    // Observe the current cycle, drive inputs for its closing edge, then advance.
    task automatic cycle(input bit mr, input bit orr, input bit rv, input logic [31:0] rpc);
        logic [15:0] h0;
        logic [31:0] e_instr;
        bit          c;
        chk("mem_instr", {31'b0, mem_instr}, {31'b0, mem_valid});
        if (mem_valid) chk("mem_align", {30'b0, mem_addr[1:0]}, 32'h0);
        if (held) begin
            chk("mem_hold_valid", {31'b0, mem_valid}, 32'h1);
            chk("mem_hold_addr", mem_addr, held_addr);
        end
        if (stall) begin
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_pc", out_pc, stall_pc);
            chk("stall_instr", out_instr, stall_instr);
        end
        mem_ready      = mr;
        mem_rdata      = mr ? word_at(mem_addr) : $urandom();
        out_ready      = orr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (out_valid && orr) begin
            h0      = hw_at(model_pc);
            c       = (h0[1:0] != 2'b11);
            e_instr = c ? {16'h0, h0} : {hw_at(model_pc + 32'd2), h0};
            chk("out_pc", out_pc, model_pc);
            chk("out_instr", out_instr, e_instr);
            chk("out_compressed", {31'b0, out_compressed}, {31'b0, c});
            if (exp_pc_q.size() > 0) begin
                chk("dir_pc", out_pc, exp_pc_q.pop_front());
                chk("dir_instr", out_instr, exp_instr_q.pop_front());
            end
            if (hs_n < 2) hs_cyc[hs_n] = cyc;
            hs_n++;
            model_pc = model_pc + (c ? 32'd2 : 32'd4);
        end
        if (rv) model_pc = {rpc[31:1], 1'b0};
        held        = mem_valid && !mr;
        held_addr   = mem_addr;
        stall       = out_valid && !orr && !rv;
        stall_pc    = out_pc;
        stall_instr = out_instr;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int n;
        cyc = 0;
        for (int i = 0; i < 128; i++) tab[i] = $urandom();
        tab[0]  = 32'h0000_0013;
        tab[1]  = 32'h0000_0093;
        tab[2]  = 32'h4501_0001;
        tab[3]  = 32'h0013_4505;
        tab[4]  = 32'h1111_0000;
        tab[64] = 32'h8082_0001;

        do_reset();
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("rst_mem_instr", {31'b0, mem_instr}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_compressed", {31'b0, out_compressed}, 32'h1);

        // Zero-wait memory, decode always ready.
        do_reset();
        push_program_exp();
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("prog_drained", exp_pc_q.size(), 32'h0);
        chk("back_to_back", hs_cyc[1] - hs_cyc[0], 32'h1);

        // Decode stalled for ten cycles.
        do_reset();
        push_program_exp();
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_mem_idle", {31'b0, mem_valid}, 32'h0);
        chk("stall_head_pc", out_pc, 32'h0);
        repeat (30) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_drained", exp_pc_q.size(), 32'h0);

        // Redirect to 0x102 (bit 0 set, ignored) while the read at 0x8 waits.
        do_reset();
        n = 0;
        while (!(mem_valid && mem_addr == 32'h8) && n < 20) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("found_req8", {31'b0, (mem_valid && mem_addr == 32'h8)}, 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        push_exp(32'h102, 32'h0000_8082);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_valid", {31'b0, mem_valid}, 32'h1);
        chk("redir_addr", mem_addr, 32'h100);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_drained", exp_pc_q.size(), 32'h0);

        // Reset asserted while a request is outstanding.
        n = 0;
        while (!mem_valid && n < 5) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("pre_rst_req", {31'b0, mem_valid}, 32'h1);
        resetn         = 1'b0;
        mem_ready      = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);

        // Random memory latency, decode back-pressure and redirects (incl. address wrap).
        for (int i = 0; i < 128; i++) tab[i] = $urandom();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 65,
                  $urandom_range(0, 99) < 3, tgt);
        end
        chk("random_progress", {31'b0, (hs_n > 500)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
